// File: rtl/capture_trigger_ctrl_if.sv
// Capture handshake between the trigger sequencer and the ADC sample FIFO block.
// The sequencer drives go and the per-sample trigger status bit; the FIFO returns stop.
interface capture_trigger_ctrl_if;
  logic adc_capture_go;
  logic adc_capture_stop;
  logic adc_trig_status;

  modport master (
    output adc_capture_go,
    output adc_trig_status,
    input  adc_capture_stop
  );

  modport slave (
    input  adc_capture_go,
    input  adc_trig_status,
    output adc_capture_stop
  );
endinterface

// File: rtl/capture_trigger_ctrl.sv
// Capture sequencer: arms on a host request, qualifies the external trigger,
// waits a post-trigger offset, then holds capture-go until the FIFO block signals stop.
module capture_trigger_ctrl #(
  parameter int OFFSET_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    adc_sampleclk,
  input  logic                    reset_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic                    trigger_now_i,
  input  logic                    ext_trig_i,
  input  logic [1:0]              trig_mode_i,
  input  logic [OFFSET_WIDTH-1:0] trig_offset_i,
  capture_trigger_ctrl_if.master  fifo_if,
  output logic                    armed_o,
  output logic                    capture_done_o,
  output logic [COUNT_WIDTH-1:0]  trig_count_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    trigSync1_q, trigS_q, trigD_q;
  logic                    arm_q;
  logic                    capSeen_q;
  logic                    go_q, armed_q, done_q, status_q;

  logic armRise;
  logic trigEvent;
  logic fire;

  assign armRise = arm_i & ~arm_q;
  assign fire    = trigEvent | trigger_now_i;

  always_comb begin
    trigEvent = 1'b0;
    unique case (trig_mode_i)
      2'b00:   trigEvent = trigS_q & ~trigD_q;
      2'b01:   trigEvent = ~trigS_q & trigD_q;
      2'b10:   trigEvent = trigS_q;
      default: trigEvent = ~trigS_q;
    endcase
  end

  // Abort overrides everything, including a trigger landing in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armRise) state_d = ARMED;
        end
        ARMED: begin
          if (fire) begin
            if (count_q != {COUNT_WIDTH{1'b1}}) count_d = count_q + COUNT_WIDTH'(1);
            if (trig_offset_i == '0) begin
              state_d = CAPTURE;
            end else begin
              cnt_d   = trig_offset_i;
              state_d = DELAY;
            end
          end
        end
        DELAY: begin
          if (cnt_q == OFFSET_WIDTH'(1)) state_d = CAPTURE;
          else                           cnt_d   = cnt_q - OFFSET_WIDTH'(1);
        end
        CAPTURE: begin
          // The FIFO's stop is registered, so it is blanked on the first capture cycle.
          if (capSeen_q && fifo_if.adc_capture_stop) state_d = DONE;
        end
        DONE: begin
          if (armRise) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_sampleclk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      count_q     <= '0;
      trigSync1_q <= 1'b0;
      trigS_q     <= 1'b0;
      trigD_q     <= 1'b0;
      arm_q       <= 1'b0;
      capSeen_q   <= 1'b0;
      go_q        <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      trigSync1_q <= ext_trig_i;
      trigS_q     <= trigSync1_q;
      trigD_q     <= trigS_q;
      arm_q       <= arm_i;
      capSeen_q   <= (state_q == CAPTURE);
      go_q        <= (state_d == CAPTURE);
      armed_q     <= (state_d == ARMED);
      done_q      <= (state_d == DONE);
      status_q    <= trig_mode_i[0] ? ~trigS_q : trigS_q;
    end
  end

  assign fifo_if.adc_capture_go  = go_q;
  assign fifo_if.adc_trig_status = status_q;
  assign armed_o                 = armed_q;
  assign capture_done_o          = done_q;
  assign trig_count_o            = count_q;
  assign state_o                 = state_q;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Self-checking bench for capture_trigger_ctrl: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_capture_trigger_ctrl;

  localparam int OW = 8;
  localparam int CW = 2;
  localparam int ST_IDLE    = 0;
  localparam int ST_ARMED   = 1;
  localparam int ST_DELAY   = 2;
  localparam int ST_CAPTURE = 3;
  localparam int ST_DONE    = 4;
  localparam int CNT_MAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, arm, abort, tnow, ext;
  logic [1:0]    mode;
  logic [OW-1:0] offset;
  logic          armed, done;
  logic [CW-1:0] count;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  // Behavioural model: trigger history, symbolic state, cycles left in delay/capture.
  bit [2:0] hist;
  bit       mArmPrev;
  bit       mStatus;
  int       mState, mDelayLeft, mCapCycles, mCount;

  capture_trigger_ctrl_if ifc ();

  capture_trigger_ctrl #(.OFFSET_WIDTH(OW), .COUNT_WIDTH(CW)) dut (
    .adc_sampleclk (clk),
    .reset_i       (reset),
    .arm_i         (arm),
    .abort_i       (abort),
    .trigger_now_i (tnow),
    .ext_trig_i    (ext),
    .trig_mode_i   (mode),
    .trig_offset_i (offset),
    .fifo_if       (ifc.master),
    .armed_o       (armed),
    .capture_done_o(done),
    .trig_count_o  (count),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  task automatic modelStep();
    bit trigS, trigD, evt, armRise;
    int nxt;
    trigS   = hist[1];
    trigD   = hist[2];
    armRise = arm && !mArmPrev;
    case (mode)
      2'd0:    evt = trigS && !trigD;
      2'd1:    evt = !trigS && trigD;
      2'd2:    evt = trigS;
      default: evt = !trigS;
    endcase
    if (reset) begin
      hist = '0; mArmPrev = 0; mStatus = 0;
      mState = ST_IDLE; mDelayLeft = 0; mCapCycles = 0; mCount = 0;
      return;
    end
    nxt = mState;
    if (abort) nxt = ST_IDLE;
    else begin
      case (mState)
        ST_IDLE:  if (armRise) nxt = ST_ARMED;
        ST_DONE:  if (armRise) nxt = ST_ARMED;
        ST_ARMED: if (evt || tnow) begin
          if (mCount < CNT_MAX) mCount++;
          if (offset == 0) begin nxt = ST_CAPTURE; mCapCycles = 0; end
          else begin nxt = ST_DELAY; mDelayLeft = int'(offset); end
        end
        ST_DELAY: begin
          mDelayLeft--;
          if (mDelayLeft == 0) begin nxt = ST_CAPTURE; mCapCycles = 0; end
        end
        ST_CAPTURE: begin
          if (mCapCycles >= 1 && ifc.adc_capture_stop) nxt = ST_DONE;
          else mCapCycles++;
        end
        default: nxt = ST_IDLE;
      endcase
    end
    mStatus  = mode[0] ? !trigS : trigS;
    hist     = {hist[1], hist[0], ext};
    mArmPrev = arm;
    mState   = nxt;
  endtask

  task automatic expectVal(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expectVal("go",     int'(ifc.adc_capture_go),  int'(mState == ST_CAPTURE));
    expectVal("armed",  int'(armed),               int'(mState == ST_ARMED));
    expectVal("done",   int'(done),                int'(mState == ST_DONE));
    expectVal("state",  int'(state),               mState);
    expectVal("count",  int'(count),               mCount);
    expectVal("status", int'(ifc.adc_trig_status), int'(mStatus));
  endtask

  task automatic applyStimulus(int n);
    repeat (n) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
    end
  endtask

  initial begin
    reset = 1; arm = 0; abort = 0; tnow = 0; ext = 0; mode = 2'd0; offset = '0;
    ifc.adc_capture_stop = 0;
    hist = '0; mArmPrev = 0; mStatus = 0;
    mState = ST_IDLE; mDelayLeft = 0; mCapCycles = 0; mCount = 0;

    applyStimulus(2);
    reset = 0;
    applyStimulus(1);
    expectVal("reset_state", int'(state), 0);

    // Arm, rising edge on the external line, zero offset
    arm = 1;
    applyStimulus(2);
    expectVal("armed_before_trig", int'(armed), 1);
    ext = 1;
    applyStimulus(3);
    expectVal("go_after_ext_rise", int'(ifc.adc_capture_go), 1);
    expectVal("count_first", int'(count), 1);
    ifc.adc_capture_stop = 1;
    applyStimulus(1);
    expectVal("stop_blanked", int'(ifc.adc_capture_go), 1);
    applyStimulus(1);
    expectVal("done_after_stop", int'(done), 1);
    ifc.adc_capture_stop = 0;

    // Re-arm from DONE, software trigger with offset 5
    arm = 0; applyStimulus(1);
    arm = 1; applyStimulus(1);
    expectVal("rearm_from_done", int'(state), ST_ARMED);
    offset = 8'd5;
    tnow = 1; applyStimulus(1); tnow = 0;
    expectVal("in_delay", int'(state), ST_DELAY);
    applyStimulus(4);
    expectVal("still_delay", int'(ifc.adc_capture_go), 0);
    applyStimulus(1);
    expectVal("go_after_offset", int'(ifc.adc_capture_go), 1);
    ifc.adc_capture_stop = 1;
    applyStimulus(2);
    ifc.adc_capture_stop = 0;

    // Abort during delay
    arm = 0; applyStimulus(1);
    arm = 1; applyStimulus(1);
    tnow = 1; applyStimulus(1); tnow = 0;
    applyStimulus(2);
    abort = 1; tnow = 1; applyStimulus(1); abort = 0; tnow = 0;
    expectVal("abort_delay", int'(state), ST_IDLE);

    // Level-high mode with line already high, then abort during capture
    mode = 2'd2; offset = '0;
    arm = 0; applyStimulus(1);
    arm = 1; applyStimulus(2);
    expectVal("level_fire", int'(ifc.adc_capture_go), 1);
    abort = 1; tnow = 1; applyStimulus(1); abort = 0; tnow = 0;
    expectVal("abort_capture", int'(ifc.adc_capture_go), 0);

    // Falling-edge mode with line high: nothing until it falls
    mode = 2'd1;
    arm = 0; applyStimulus(1);
    arm = 1; applyStimulus(5);
    expectVal("fall_wait", int'(state), ST_ARMED);
    ext = 0; applyStimulus(3);
    expectVal("fall_fire", int'(state), ST_CAPTURE);
    expectVal("count_saturated", int'(count), CNT_MAX);

    // Reset in the middle of a capture
    reset = 1; applyStimulus(1); reset = 0;
    expectVal("reset_mid_go", int'(ifc.adc_capture_go), 0);
    applyStimulus(1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) arm = ~arm;
      abort = ($urandom_range(0, 39) == 0);
      tnow  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) ext = ~ext;
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) offset = OW'($urandom_range(0, 6));
      ifc.adc_capture_stop = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
